// File: rtl/multi_norm_multiplier_pkg.sv
// Shared FPU mantissa-datapath package.
// Holds the sequencing state type and the default mantissa width used by
// the multi-cycle multiplier and the multi-cycle normalized divider.
package multi_norm_multiplier_pkg;

  // Default mantissa width, leading 1 included (single precision).
  localparam int MANT_WIDTH = 24;

  // Sequencing states shared by the multi-cycle mantissa units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2
  } state_t;

endpackage : multi_norm_multiplier_pkg

// File: rtl/multi_norm_multiplier_mantissa_normalizer.sv
// mantissa_normalizer
// Combinational normalizer for a raw 2*INWIDTH-bit mantissa product whose
// value lies in [1,4). It shifts the product so that the leading 1 sits at
// the MSB of the result mantissa and extracts guard, round and sticky bits.
//
// Optional feature: MULTI_NORM_MULTIPLIER_STICKY_EN
//   defined     - sticky is the OR of every bit below the round bit
//   not defined - sticky is tied to 0 and the OR-reduction is not built
//
// Ports
//   p        in  2*INWIDTH  raw product, binary point below bit 2*INWIDTH-2
//   product  out OUTWIDTH   normalized mantissa, leading 1 at MSB
//   guard    out 1          first bit below product LSB
//   round    out 1          second bit below product LSB
//   sticky   out 1          OR of all remaining lower bits
//   overflow out 1          raw product >= 2.0
module mantissa_normalizer #(
  parameter int INWIDTH  = 24,
  parameter int OUTWIDTH = 24
) (
  input  logic [2*INWIDTH-1:0] p,
  output logic [OUTWIDTH-1:0]  product,
  output logic                 guard,
  output logic                 round,
  output logic                 sticky,
  output logic                 overflow
);

  localparam int PW = 2 * INWIDTH;
  // Bits left below the round bit; at least 1 for any legal OUTWIDTH.
  localparam int LOW = PW - OUTWIDTH - 2;

  logic [PW-1:0] shifted_s;

  // Align the leading 1 to the MSB: products below 2.0 have it one bit lower.
  always_comb begin
    shifted_s = p;
    if (p[PW-1]) begin
      shifted_s = p;
    end else begin
      shifted_s = {p[PW-2:0], 1'b0};
    end
  end

  assign overflow = p[PW-1];
  assign product  = shifted_s[PW-1 -: OUTWIDTH];
  assign guard    = shifted_s[PW-1-OUTWIDTH];
  assign round    = shifted_s[PW-2-OUTWIDTH];

`ifdef MULTI_NORM_MULTIPLIER_STICKY_EN
  assign sticky = |shifted_s[LOW-1:0];
`else
  // Low bits are only needed for sticky; keep them visibly consumed.
  logic unused_low_s;
  assign unused_low_s = |shifted_s[LOW-1:0];
  assign sticky       = 1'b0;
`endif

endmodule : mantissa_normalizer

// File: rtl/multi_norm_multiplier.sv
// multi_norm_multiplier
// Multi-cycle shift-add multiplier for two normalized mantissas (1.xxx).
// One partial-product step per cycle for INWIDTH cycles, then a single
// normalization cycle; results are registered and held until the next
// operation completes.
//
// Optional feature: MULTI_NORM_MULTIPLIER_STICKY_EN (see mantissa_normalizer)
//
// Ports
//   clk              in  1         clock
//   reset            in  1         asynchronous, active-high reset
//   start            in  1         begin operation, sampled only in IDLE
//   multiplicand_in  in  INWIDTH   normalized operand A
//   multiplier_in    in  INWIDTH   normalized operand B
//   busy             out 1         operation in progress
//   done             out 1         one-cycle pulse, results valid
//   product          out OUTWIDTH  normalized mantissa, leading 1 at MSB
//   guard            out 1         first bit below product LSB
//   round            out 1         second bit below product LSB
//   sticky           out 1         OR of all remaining lower bits
//   overflow         out 1         raw product >= 2.0, bump the exponent
module multi_norm_multiplier
  import multi_norm_multiplier_pkg::*;
#(
  parameter int INWIDTH    = MANT_WIDTH,
  parameter int OUTWIDTH   = MANT_WIDTH,
  parameter int COUNTWIDTH = $clog2(INWIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [INWIDTH-1:0]  multiplicand_in,
  input  logic [INWIDTH-1:0]  multiplier_in,
  output logic                busy,
  output logic                done,
  output logic [OUTWIDTH-1:0] product,
  output logic                guard,
  output logic                round,
  output logic                sticky,
  output logic                overflow
);

  localparam int CNT_W = COUNTWIDTH + 1;
  // Count value seen during the final CALC step.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(INWIDTH - 1);

  state_t              state_r;
  logic [INWIDTH-1:0]  mcand_r;
  logic [INWIDTH-1:0]  acc_r;
  logic [INWIDTH-1:0]  mplr_r;
  logic [CNT_W-1:0]    count_r;
  logic                busy_r;
  logic                done_r;
  logic [OUTWIDTH-1:0] product_r;
  logic                guard_r;
  logic                round_r;
  logic                sticky_r;
  logic                overflow_r;

  logic [INWIDTH:0]    sum_s;
  logic [OUTWIDTH-1:0] norm_product_s;
  logic                norm_guard_s;
  logic                norm_round_s;
  logic                norm_sticky_s;
  logic                norm_overflow_s;

  // Partial-product add: carry-out becomes the new MSB of the accumulator.
  always_comb begin
    sum_s = {1'b0, acc_r};
    if (mplr_r[0]) begin
      sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r};
    end
  end

  mantissa_normalizer #(
    .INWIDTH  (INWIDTH),
    .OUTWIDTH (OUTWIDTH)
  ) u_normalizer (
    .p        ({acc_r, mplr_r}),
    .product  (norm_product_s),
    .guard    (norm_guard_s),
    .round    (norm_round_s),
    .sticky   (norm_sticky_s),
    .overflow (norm_overflow_s)
  );

  // Sequencer: load operands, run INWIDTH shift-add steps, register result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      mcand_r    <= '0;
      acc_r      <= '0;
      mplr_r     <= '0;
      count_r    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      product_r  <= '0;
      guard_r    <= 1'b0;
      round_r    <= 1'b0;
      sticky_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r <= multiplicand_in;
            mplr_r  <= multiplier_in;
            acc_r   <= '0;
            count_r <= '0;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          // The multiplier register doubles as the low half of the product.
          acc_r   <= sum_s[INWIDTH:1];
          mplr_r  <= {sum_s[0], mplr_r[INWIDTH-1:1]};
          count_r <= count_r + CNT_W'(1);
          if (count_r == LAST_STEP) begin
            state_r <= NORM;
          end else begin
            state_r <= CALC;
          end
        end
        NORM: begin
          product_r  <= norm_product_s;
          guard_r    <= norm_guard_s;
          round_r    <= norm_round_s;
          sticky_r   <= norm_sticky_s;
          overflow_r <= norm_overflow_s;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign product  = product_r;
  assign guard    = guard_r;
  assign round    = round_r;
  assign sticky   = sticky_r;
  assign overflow = overflow_r;

endmodule : multi_norm_multiplier

// File: tb/tb_multi_norm_multiplier.sv
// Directed self-checking bench for multi_norm_multiplier (default widths).
module tb_multi_norm_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] multiplicand_in;
  logic [23:0] multiplier_in;
  logic        busy;
  logic        done;
  logic [23:0] product;
  logic        guard;
  logic        round;
  logic        sticky;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  bit both_high = 1'b0;
  bit saw_done = 1'b0;
  int lat;

`ifdef MULTI_NORM_MULTIPLIER_STICKY_EN
  localparam logic STICKY_FF = 1'b1;
`else
  localparam logic STICKY_FF = 1'b0;
`endif

  multi_norm_multiplier dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .multiplicand_in (multiplicand_in),
    .multiplier_in   (multiplier_in),
    .busy            (busy),
    .done            (done),
    .product         (product),
    .guard           (guard),
    .round           (round),
    .sticky          (sticky),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) both_high = 1'b1;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands for one edge, then confirm busy.
  task automatic launch(input logic [23:0] x, input logic [23:0] y);
    start = 1'b1;
    multiplicand_in = x;
    multiplier_in = y;
    @(negedge clk);
    start = 1'b0;
    multiplicand_in = 24'h123456;
    multiplier_in = 24'h654321;
    check("busy_after_start", {47'd0, busy}, 48'd1);
    check("no_done_after_start", {47'd0, done}, 48'd0);
  endtask

  // Count cycles until done; optionally pulse start at cycle inject_at.
  task automatic wait_done(input int inject_at, output int n);
    n = 0;
    while (!done && n < 40) begin
      if (n == inject_at) begin
        start = 1'b1;
        multiplicand_in = 24'h800000;
        multiplier_in = 24'h800000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 48'(n), 48'd25);
  endtask

  task automatic check_result(input string tag, input logic [23:0] p, input logic g,
                              input logic r, input logic s, input logic o);
    check({tag, "_product"}, {24'd0, product}, {24'd0, p});
    check({tag, "_grs"}, {45'd0, guard, round, sticky}, {45'd0, g, r, s});
    check({tag, "_overflow"}, {47'd0, overflow}, {47'd0, o});
  endtask

  task automatic after_done(input string tag, input logic [23:0] p);
    @(negedge clk);
    check({tag, "_done_pulse"}, {46'd0, done, busy}, 48'd0);
    check({tag, "_hold"}, {24'd0, product}, {24'd0, p});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplicand_in = 24'h0;
    multiplier_in = 24'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {19'd0, busy, done, product, guard, round, sticky, overflow}, 48'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1.0 x 1.0
    launch(24'h800000, 24'h800000);
    wait_done(-1, lat);
    check_result("one", 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    after_done("one", 24'h800000);

    // 1.5 x 1.5 = 2.25
    launch(24'hC00000, 24'hC00000);
    wait_done(-1, lat);
    check_result("c0", 24'h900000, 1'b0, 1'b0, 1'b0, 1'b1);
    after_done("c0", 24'h900000);

    // all ones: P = FFFFFE000001
    launch(24'hFFFFFF, 24'hFFFFFF);
    wait_done(-1, lat);
    check_result("ff", 24'hFFFFFE, 1'b0, 1'b0, STICKY_FF, 1'b1);
    after_done("ff", 24'hFFFFFE);

    // P = 600000C00000, no overflow, guard set
    launch(24'h800001, 24'hC00000);
    wait_done(-1, lat);
    check_result("g1", 24'hC00001, 1'b1, 1'b0, 1'b0, 1'b0);
    after_done("g1", 24'hC00001);

    // start while busy is ignored, then back-to-back start on the done cycle
    launch(24'hC00000, 24'hC00000);
    wait_done(5, lat);
    check_result("ign", 24'h900000, 1'b0, 1'b0, 1'b0, 1'b1);
    launch(24'hFFFFFF, 24'hFFFFFF);
    wait_done(-1, lat);
    check_result("b2b", 24'hFFFFFE, 1'b0, 1'b0, STICKY_FF, 1'b1);
    after_done("b2b", 24'hFFFFFE);

    // reset mid-operation
    launch(24'h800001, 24'hC00000);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("reset_mid", {19'd0, busy, done, product, guard, round, sticky, overflow}, 48'd0);
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_reset", {47'd0, saw_done}, 48'd0);
    launch(24'h800001, 24'hC00000);
    wait_done(-1, lat);
    check_result("post_reset", 24'hC00001, 1'b1, 1'b0, 1'b0, 1'b0);
    after_done("post_reset", 24'hC00001);

    check("busy_done_exclusive", {47'd0, both_high}, 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multi_norm_multiplier

// File: doc/multi_norm_multiplier.md
# multi_norm_multiplier

Multi-cycle shift-add multiplier for two normalized mantissas (format 1.xxx…x, MSB = 1); the multiplicative counterpart of the team's multi-cycle normalized divider in the FPU datapath. Accepts operands on a start/busy/done handshake, produces one partial-product step per cycle, then normalizes the product to [1,2). Emits the mantissa plus guard, round and sticky bits and an overflow flag for exponent adjustment by the rounding stage.

## Interface
- INWIDTH, 24, operand width including leading 1
- OUTWIDTH, 24, result mantissa width; legal range 2..2*INWIDTH-3
- COUNTWIDTH, $clog2(INWIDTH), step counter width (counter is COUNTWIDTH+1 bits)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- multiplicand_in  in  INWIDTH  normalized operand A
- multiplier_in  in  INWIDTH  normalized operand B
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, results valid
- product  out  OUTWIDTH  normalized mantissa, leading 1 at MSB
- guard  out  1  first bit below product LSB
- round  out  1  second bit below product LSB
- sticky  out  1  OR of all remaining lower bits
- overflow  out  1  raw product ≥ 2.0; exponent must be incremented

## Operation
- Registers: mcand (INWIDTH), acc (INWIDTH), mplr (INWIDTH), count, state, all outputs. All reset to 0, state to IDLE.
- States: IDLE, CALC, NORM.
- IDLE: on start, load mcand = multiplicand_in, mplr = multiplier_in, acc = 0, count = 0, busy_next = 1, go to CALC. Otherwise stay; busy = 0.
- CALC step: sum (INWIDTH+1 bits) = {0, acc} + (mplr[0] ? mcand : 0); {acc, mplr} = {sum, mplr[INWIDTH-1:1]}; count++. After step INWIDTH (count reaches INWIDTH), go to NORM.
- Raw product P = {acc, mplr}, 2*INWIDTH bits, value in [1,4).
- NORM: overflow = P[2W-1]. If overflow, product = P[2W-1 -: OUTWIDTH]; else product = P[2W-2 -: OUTWIDTH]. guard/round = next two lower bits; sticky = OR of all bits below round. Register outputs, pulse done, clear busy, go to IDLE.
- product/guard/round/sticky/overflow hold their values until the next NORM; unaffected by subsequent start until then.
- start while busy (CALC/NORM) is ignored; operand inputs are don't-care outside the start cycle.
- Non-normalized operands (MSB = 0): behaviour undefined; no error output.

## Timing
- start sampled at edge E0 → busy = 1 after E0.
- CALC steps at E1..E_INWIDTH; NORM registers results at E_(INWIDTH+1).
- After E_(INWIDTH+1): done = 1 for exactly one cycle, busy = 0, results valid. Latency 25 cycles at default.
- Back-to-back: start high while done = 1 (state IDLE) is accepted; next done exactly INWIDTH+1 cycles later.
- busy and done never high together.
- Reset mid-operation: all registers cleared immediately; no done pulse; outputs 0; IDLE on release.

## Configuration
- MULTI_NORM_MULTIPLIER_STICKY_EN defined: sticky computed as specified.
- Not defined: sticky driven constant 0; the OR-reduction logic is removed. guard, round and product are unchanged.

## Structure
- Shared FPU package: state enum (IDLE/CALC/NORM) and default mantissa width constant (24), reused with the divider.
- One natural sub-module: mantissa_normalizer, a combinational block taking P and returning product/guard/round/sticky/overflow; shareable with other FPU units.

## Test plan
- 24'h800000 × 24'h800000 → done after 25 cycles; product 24'h800000, overflow 0, g/r/s 0/0/0.
- 24'hC00000 × 24'hC00000 (2.25) → product 24'h900000, overflow 1, g/r/s 0/0/0.
- 24'hFFFFFF × 24'hFFFFFF (P = 48'hFFFFFE000001) → product 24'hFFFFFE, overflow 1, g/r/s 0/0/1; with macro undefined sticky 0.
- 24'h800001 × 24'hC00000 (P = 48'h600000C00000) → product 24'hC00001, overflow 0, guard 1, round 0, sticky 0.
- start pulsed again at cycle 5 of an operation → ignored; single done at cycle 25 with first result; then start on the done cycle → second done exactly 25 cycles later.
- reset asserted at cycle 10 → all outputs 0 immediately, no done pulse; new start after release completes normally.
